// File: rtl/life_col_n.sv
// life_col_n: one column of Game of Life cells (B3/S23), ROWS tall.
// Holds cell state, steps a generation on enable, accepts single-cell writes,
// and reports change / still-run / generation-count activity.
// Optional build macro: LIFE_COL_POPCOUNT_EN adds the registered pop_count port.
module life_col_n #(
  parameter int ROWS        = 8,
  parameter int ROW_W       = 3,
  parameter int GEN_W       = 16,
  parameter int STABLE_GENS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ROWS-1:0]  w_col,
  input  logic [ROWS-1:0]  e_col,
  input  logic             n,
  input  logic             s,
  input  logic             nw,
  input  logic             ne,
  input  logic             sw,
  input  logic             se,
  input  logic             write_enb,
  input  logic             val,
  input  logic [ROW_W-1:0] row,
  output logic [ROWS-1:0]  alive_col,
  output logic             changed,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
`ifdef LIFE_COL_POPCOUNT_EN
  ,
  output logic [ROW_W:0]   pop_count
`endif
);

  localparam int STILL_W = $clog2(STABLE_GENS + 1);
  localparam logic [STILL_W-1:0] STILL_MAX = STILL_W'(STABLE_GENS);

  logic [ROWS-1:0]    alive_q, alive_d;
  logic               changed_q, changed_d;
  logic               stable_q, stable_d;
  logic [STILL_W-1:0] still_q, still_d;
  logic [GEN_W-1:0]   gen_q, gen_d;

  logic [ROWS-1:0]    wr_hit;
  logic               wr_valid;
  logic [ROWS-1:0]    life_nxt;
  logic [ROWS-1:0]    step_diff;

  // One-hot write target; out-of-range rows match nothing and are dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (write_enb && (row == ROW_W'(i))) wr_hit[i] = 1'b1;
    end
    wr_valid = |wr_hit;
  end

  // B3/S23 next state for every cell, with the column ends padded by the edge inputs.
  always_comb begin
    logic [ROWS+1:0] a_ext;
    logic [ROWS+1:0] w_ext;
    logic [ROWS+1:0] e_ext;
    logic [3:0]      cnt;
    a_ext    = {s, alive_q, n};
    w_ext    = {sw, w_col, nw};
    e_ext    = {se, e_col, ne};
    cnt      = '0;
    life_nxt = '0;
    for (int i = 0; i < ROWS; i++) begin
      cnt = 4'(w_ext[i]) + 4'(w_ext[i+1]) + 4'(w_ext[i+2])
          + 4'(e_ext[i]) + 4'(e_ext[i+1]) + 4'(e_ext[i+2])
          + 4'(a_ext[i]) + 4'(a_ext[i+2]);
      life_nxt[i] = (cnt == 4'd3) || ((cnt == 4'd2) && alive_q[i]);
    end
  end

  // Next-state for cells and activity tracking; a write overrides the step for its cell only.
  always_comb begin
    alive_d   = alive_q;
    changed_d = changed_q;
    still_d   = still_q;
    gen_d     = gen_q;
    step_diff = '0;
    if (enable) begin
      step_diff = (life_nxt ^ alive_q) & ~wr_hit;
      alive_d   = life_nxt;
      changed_d = |step_diff;
      gen_d     = gen_q + GEN_W'(1);
    end
    alive_d = (alive_d & ~wr_hit) | (wr_hit & {ROWS{val}});
    if (wr_valid || (enable && (|step_diff))) begin
      still_d = '0;
    end else if (enable && (still_q != STILL_MAX)) begin
      still_d = still_q + STILL_W'(1);
    end
    stable_d = (still_d == STILL_MAX);
  end

`ifdef LIFE_COL_POPCOUNT_EN
  logic [ROW_W:0] pop_q, pop_d;

  // Population of the next state, so pop_count lines up with alive_col.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      pop_d = pop_d + (ROW_W+1)'(alive_d[i]);
    end
  end

  // Population register.
  always_ff @(posedge clk) begin
    if (!reset) pop_q <= '0;
    else        pop_q <= pop_d;
  end

  assign pop_count = pop_q;
`endif

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alive_q   <= '0;
      changed_q <= 1'b0;
      stable_q  <= 1'b0;
      still_q   <= '0;
      gen_q     <= '0;
    end else begin
      alive_q   <= alive_d;
      changed_q <= changed_d;
      stable_q  <= stable_d;
      still_q   <= still_d;
      gen_q     <= gen_d;
    end
  end

  assign alive_col = alive_q;
  assign changed   = changed_q;
  assign stable    = stable_q;
  assign gen_count = gen_q;

endmodule
